tf_mul_stage: RTL and testbench

//  Parametrised twiddle-factor multiply stage placed between a radix-R butterfly and the next stage in the FFT/NTT pipeline.
//  - Computes out[k] = (data[k] * tf[k]) mod N for lanes 1..RADIX-1.
//  - Lane 0 has an implied twiddle of 1 and passes through a latency-matched delay line.
//  - Adds what the fixed radix-16 stage lacks: valid/last tracking, stall, a global bypass, and per-beat modulus capture.

---
 rtl/tf_mul_stage_pkg.sv | 14 +
 rtl/tf_mul_stage_if.sv | 28 ++
 rtl/tf_mul_stage_mod_mul_pipe.sv | 66 ++++++
 rtl/tf_mul_stage.sv | 83 ++++++++
 tb/tb_tf_mul_stage.sv | 368 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tf_mul_stage_pkg.sv
// Shared defaults and small helpers for the twiddle-factor multiply stage.
package tf_mul_stage_pkg;

    localparam int RADIX_DEF       = 16;
    localparam int D_WIDTH_DEF     = 64;
    localparam int MUL_LAT_DEF     = 4;
    localparam int FRAME_BEATS_DEF = 4096;

    // Beat counter width; never below one bit so tiny frames still elaborate.
    function automatic int cnt_width(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/tf_mul_stage_if.sv
// Beat-level bus of the twiddle multiply stage; lane k sits in element k of each packed lane array.
interface tf_mul_stage_if #(
    parameter int RADIX   = tf_mul_stage_pkg::RADIX_DEF,
    parameter int D_WIDTH = tf_mul_stage_pkg::D_WIDTH_DEF
) ();
    import tf_mul_stage_pkg::*;

    logic                          en;
    logic                          in_valid;
    logic                          bypass;
    logic [D_WIDTH-1:0]            mod_n;
    logic [RADIX-1:0][D_WIDTH-1:0] in_data;
    logic [RADIX-1:0][D_WIDTH-1:0] tf_in;
    logic                          out_valid;
    logic                          out_last;
    logic [RADIX-1:0][D_WIDTH-1:0] out_data;

    modport master (
        output en, in_valid, bypass, mod_n, in_data, tf_in,
        input  out_valid, out_last, out_data
    );

    modport slave (
        input  en, in_valid, bypass, mod_n, in_data, tf_in,
        output out_valid, out_last, out_data
    );

endinterface

// File: rtl/tf_mul_stage_mod_mul_pipe.sv
// Pipelined modular multiplier: product register, then % reduction, then delay to MUL_LAT stages.
// The modulus rides along with the product so every beat reduces by its own N.
module tf_mul_stage_mod_mul_pipe #(
    parameter int D_WIDTH = tf_mul_stage_pkg::D_WIDTH_DEF,
    parameter int MUL_LAT = tf_mul_stage_pkg::MUL_LAT_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en_i,
    input  logic [D_WIDTH-1:0] a_i,
    input  logic [D_WIDTH-1:0] b_i,
    input  logic [D_WIDTH-1:0] n_i,
    output logic [D_WIDTH-1:0] s_o
);
    import tf_mul_stage_pkg::*;

    localparam int PW = 2 * D_WIDTH;

    logic [PW-1:0] prod_d;
    assign prod_d = PW'(a_i) * PW'(b_i);

    generate
        if (MUL_LAT == 1) begin : g_single
            logic [D_WIDTH-1:0] s_q, s_d;

            always_comb begin
                s_d = '0;
                if (n_i != '0) s_d = D_WIDTH'(prod_d % PW'(n_i));
            end

            always_ff @(posedge clk) begin
                if (!rst_n)    s_q <= '0;
                else if (en_i) s_q <= s_d;
            end

            assign s_o = s_q;
        end else begin : g_multi
            logic [PW-1:0]                   prod_q;
            logic [D_WIDTH-1:0]              n_q;
            logic [D_WIDTH-1:0]              rem_d;
            logic [MUL_LAT-2:0][D_WIDTH-1:0] res_q;

            // N==0 has no meaningful residue; force the lane to zero instead.
            always_comb begin
                rem_d = '0;
                if (n_q != '0) rem_d = D_WIDTH'(prod_q % PW'(n_q));
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    prod_q <= '0;
                    n_q    <= '0;
                    res_q  <= '0;
                end else if (en_i) begin
                    prod_q   <= prod_d;
                    n_q      <= n_i;
                    res_q[0] <= rem_d;
                    for (int i = 1; i < MUL_LAT - 1; i++) res_q[i] <= res_q[i-1];
                end
            end

            assign s_o = res_q[MUL_LAT-2];
        end
    endgenerate

endmodule

// File: rtl/tf_mul_stage.sv
// Twiddle-factor multiply stage: lanes 1..RADIX-1 get (data*tf) mod N, lane 0 is a matched delay,
// with valid/bypass tracking, global stall and a frame beat counter driving out_last.
module tf_mul_stage #(
    parameter int RADIX       = tf_mul_stage_pkg::RADIX_DEF,
    parameter int D_WIDTH     = tf_mul_stage_pkg::D_WIDTH_DEF,
    parameter int MUL_LAT     = tf_mul_stage_pkg::MUL_LAT_DEF,
    parameter int FRAME_BEATS = tf_mul_stage_pkg::FRAME_BEATS_DEF
) (
    input logic           clk,
    input logic           rst_n,
    tf_mul_stage_if.slave bus
);
    import tf_mul_stage_pkg::*;

    localparam int              CW        = cnt_width(FRAME_BEATS);
    localparam int              TAIL      = MUL_LAT - 1;
    localparam logic [CW-1:0]   LAST_BEAT = CW'(FRAME_BEATS - 1);

    logic [MUL_LAT-1:0]                           vld_pipe_q;
    logic [MUL_LAT-1:0]                           byp_pipe_q;
    logic [MUL_LAT-1:0][RADIX-1:0][D_WIDTH-1:0]   raw_q;
    logic [RADIX-1:1][D_WIDTH-1:0]                mul_s;
    logic [RADIX-1:0][D_WIDTH-1:0]                out_d;
    logic [CW-1:0]                                cnt_q, cnt_d;
    logic [D_WIDTH-1:0]                           unused_tf0;

    // Lane 0 has an implied twiddle of 1, so its twiddle input is never looked at.
    assign unused_tf0 = bus.tf_in[0];

    generate
        for (genvar k = 1; k < RADIX; k++) begin : g_lane
            tf_mul_stage_mod_mul_pipe #(
                .D_WIDTH (D_WIDTH),
                .MUL_LAT (MUL_LAT)
            ) u_mul (
                .clk   (clk),
                .rst_n (rst_n),
                .en_i  (bus.en),
                .a_i   (bus.in_data[k]),
                .b_i   (bus.tf_in[k]),
                .n_i   (bus.mod_n),
                .s_o   (mul_s[k])
            );
        end
    endgenerate

    // Counts beats leaving the output, so the beat sitting there sees its own frame index.
    always_comb begin
        cnt_d = cnt_q;
        if (vld_pipe_q[TAIL]) cnt_d = (cnt_q == LAST_BEAT) ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_pipe_q <= '0;
            byp_pipe_q <= '0;
            raw_q      <= '0;
            cnt_q      <= '0;
        end else if (bus.en) begin
            vld_pipe_q[0] <= bus.in_valid;
            byp_pipe_q[0] <= bus.bypass;
            raw_q[0]      <= bus.in_data;
            for (int i = 1; i < MUL_LAT; i++) begin
                vld_pipe_q[i] <= vld_pipe_q[i-1];
                byp_pipe_q[i] <= byp_pipe_q[i-1];
                raw_q[i]      <= raw_q[i-1];
            end
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        out_d = raw_q[TAIL];
        if (!byp_pipe_q[TAIL]) begin
            for (int k = 1; k < RADIX; k++) out_d[k] = mul_s[k];
        end
    end

    assign bus.out_data  = out_d;
    assign bus.out_valid = vld_pipe_q[TAIL];
    assign bus.out_last  = vld_pipe_q[TAIL] && (cnt_q == LAST_BEAT);

endmodule

// File: tb/tb_tf_mul_stage.sv
// Self-checking bench for tf_mul_stage: directed scenarios plus randomized traffic against a
// beat-queue reference model (expected result, frame position and due time per accepted beat).
module tb_tf_mul_stage;

    localparam int R  = 4;
    localparam int D  = 64;
    localparam int L  = 4;
    localparam int FB = 4;

    typedef logic [R-1:0][D-1:0] lanes_t;
    typedef struct {
        lanes_t data;
        logic   last;
        int     due;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tf_mul_stage_if #(.RADIX(R), .D_WIDTH(D)) bus ();

    tf_mul_stage #(
        .RADIX       (R),
        .D_WIDTH     (D),
        .MUL_LAT     (L),
        .FRAME_BEATS (FB)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int     checks = 0;
    int     errors = 0;
    exp_t   q[$];
    int     en_edges = 0;
    int     seq = 0;
    logic   exp_valid = 1'b0;
    logic   exp_last = 1'b0;
    lanes_t exp_data = '0;

    function automatic logic [D-1:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    function automatic lanes_t rnd_lanes();
        lanes_t r;
        for (int k = 0; k < R; k++) r[k] = rnd64();
        return r;
    endfunction

    // Spec-level arithmetic: exact 128-bit product reduced mod N; lane 0 and bypass beats stay raw.
    function automatic lanes_t ref_beat(input lanes_t a, input lanes_t b, input logic [D-1:0] n,
                                        input logic byp);
        lanes_t         r;
        logic [2*D-1:0] p;
        for (int k = 0; k < R; k++) begin
            p = {64'd0, a[k]} * {64'd0, b[k]};
            if (k == 0 || byp) r[k] = a[k];
            else if (n == 64'd0) r[k] = '0;
            else r[k] = D'(p % {64'd0, n});
        end
        return r;
    endfunction

    // Drive one cycle, advance the model, and leave expectations ready at the following negedge.
    task automatic tick(input logic rst, input logic en, input logic v, input logic byp,
                        input logic [D-1:0] n, input lanes_t a, input lanes_t b);
        exp_t e;
        rst_n        = !rst;
        bus.en       = en;
        bus.in_valid = v;
        bus.bypass   = byp;
        bus.mod_n    = n;
        bus.in_data  = a;
        bus.tf_in    = b;
        @(posedge clk);
        if (rst) begin
            q.delete();
            en_edges = 0;
            seq      = 0;
        end else if (en) begin
            en_edges++;
            if (v) begin
                e.data = ref_beat(a, b, n, byp);
                e.last = (seq % FB) == FB - 1;
                e.due  = en_edges + L - 1;
                q.push_back(e);
                seq++;
            end
            while (q.size() > 0 && q[0].due < en_edges) void'(q.pop_front());
        end
        @(negedge clk);
        exp_valid = (q.size() > 0) && (q[0].due == en_edges);
        exp_last  = exp_valid && q[0].last;
        exp_data  = exp_valid ? q[0].data : '0;
    endtask

    task automatic idle();
        tick(1'b0, 1'b1, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic test_reset();
        for (int c = 0; c < 3; c++) tick(1'b1, 1'b1, 1'b1, 1'b0, 64'd17, rnd_lanes(), rnd_lanes());
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctl valid=%b last=%b want 0 0", bus.out_valid, bus.out_last);
        end
        checks++;
        if (bus.out_data !== '0) begin
            errors++;
            $display("FAIL reset_data got %h want 0", bus.out_data);
        end
    endtask

    task automatic test_basic();
        lanes_t a, b;
        a = '0; b = '0;
        a[0] = 64'hDEAD;
        a[1] = 64'd5;  b[1] = 64'd7;
        a[2] = 64'd16; b[2] = 64'd16;
        a[3] = rnd64(); b[3] = rnd64();
        tick(1'b0, 1'b1, 1'b1, 1'b0, 64'd17, a, b);
        for (int c = 2; c <= 7; c++) begin
            idle();
            checks++;
            if (bus.out_valid !== (c == 4)) begin
                errors++;
                $display("FAIL basic_valid cyc=%0d got %b want %b", c, bus.out_valid, (c == 4));
            end
            if (c == 4) begin
                checks++;
                if (bus.out_data[0] !== 64'hDEAD || bus.out_data[1] !== 64'd1 ||
                    bus.out_data[2] !== 64'd1 || bus.out_last !== 1'b0) begin
                    errors++;
                    $display("FAIL basic_lanes got l0=%h l1=%0d l2=%0d last=%b want dead 1 1 0",
                             bus.out_data[0], bus.out_data[1], bus.out_data[2], bus.out_last);
                end
                checks++;
                if (bus.out_data !== exp_data) begin
                    errors++;
                    $display("FAIL basic_model got %h want %h", bus.out_data, exp_data);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [D-1:0] n;
        logic         en, v, prev_valid;
        lanes_t       prev;
        int           nout;
        n    = rnd64();
        nout = 0;
        for (int s = 0; s < 22; s++) begin
            en         = !(s >= 3 && s < 6);
            v          = (s < 11);
            prev       = bus.out_data;
            prev_valid = bus.out_valid;
            tick(1'b0, en, v, 1'b0, n, rnd_lanes(), rnd_lanes());
            if (bus.out_valid === 1'b1) nout++;
            checks++;
            if (bus.out_valid !== exp_valid || bus.out_last !== exp_last) begin
                errors++;
                $display("FAIL b2b_ctl s=%0d got v=%b l=%b want v=%b l=%b", s, bus.out_valid,
                         bus.out_last, exp_valid, exp_last);
            end
            if (exp_valid) begin
                checks++;
                if (bus.out_data !== exp_data) begin
                    errors++;
                    $display("FAIL b2b_data s=%0d got %h want %h", s, bus.out_data, exp_data);
                end
            end
            if (!en) begin
                checks++;
                if (bus.out_data !== prev || bus.out_valid !== prev_valid) begin
                    errors++;
                    $display("FAIL b2b_freeze s=%0d got %h want %h", s, bus.out_data, prev);
                end
            end
        end
        checks++;
        if (nout != 8) begin
            errors++;
            $display("FAIL b2b_count got %0d want 8", nout);
        end
    endtask

    task automatic test_bypass_mod();
        lanes_t a1, b1, a2, b2;
        a1 = rnd_lanes(); b1 = rnd_lanes(); a1[1] = 64'd100; b1[1] = 64'd3;
        a2 = rnd_lanes(); b2 = rnd_lanes(); a2[1] = 64'd100; b2[1] = 64'd3;
        tick(1'b0, 1'b1, 1'b1, 1'b1, 64'd17, a1, b1);
        tick(1'b0, 1'b1, 1'b1, 1'b0, 64'd97, a2, b2);
        for (int c = 3; c <= 8; c++) begin
            // Flip bypass and N on bubbles; in-flight beats must not notice.
            tick(1'b0, 1'b1, 1'b0, 1'b1, 64'd5, rnd_lanes(), rnd_lanes());
            if (c == 4) begin
                checks++;
                if (bus.out_valid !== 1'b1 || bus.out_data !== a1) begin
                    errors++;
                    $display("FAIL bypass_beat v=%b got %h want %h", bus.out_valid, bus.out_data, a1);
                end
            end
            if (c == 5) begin
                checks++;
                if (bus.out_valid !== 1'b1 || bus.out_data[1] !== 64'd9 || bus.out_data[0] !== a2[0]) begin
                    errors++;
                    $display("FAIL mod97_beat v=%b l1=%0d l0=%h want 1 9 %h", bus.out_valid,
                             bus.out_data[1], bus.out_data[0], a2[0]);
                end
                checks++;
                if (bus.out_data !== exp_data) begin
                    errors++;
                    $display("FAIL mod97_model got %h want %h", bus.out_data, exp_data);
                end
            end
        end
    endtask

    task automatic test_frame();
        int sent, nout;
        logic v;
        sent = 0;
        nout = 0;
        tick(1'b1, 1'b1, 1'b0, 1'b0, '0, '0, '0);
        for (int s = 0; s < 60 && (sent < 10 || s < sent + 2 * L + 20); s++) begin
            v = (sent < 10) && ($urandom_range(0, 2) != 0);
            if (v) sent++;
            tick(1'b0, 1'b1, v, $urandom_range(0, 1) == 0, rnd64(), rnd_lanes(), rnd_lanes());
            if (bus.out_valid === 1'b1) begin
                nout++;
                checks++;
                if (bus.out_last !== (nout == 4 || nout == 8)) begin
                    errors++;
                    $display("FAIL frame_last beat=%0d got %b want %b", nout, bus.out_last,
                             (nout == 4 || nout == 8));
                end
            end
        end
        checks++;
        if (nout != 10) begin
            errors++;
            $display("FAIL frame_count got %0d want 10", nout);
        end
    endtask

    task automatic test_reset_midflight();
        int nout;
        nout = 0;
        for (int c = 0; c < 3; c++) tick(1'b0, 1'b1, 1'b1, 1'b0, 64'd13, rnd_lanes(), rnd_lanes());
        tick(1'b1, 1'b0, 1'b1, 1'b0, 64'd13, rnd_lanes(), rnd_lanes());
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== '0) begin
            errors++;
            $display("FAIL midreset_clear v=%b got %h want 0 0", bus.out_valid, bus.out_data);
        end
        for (int c = 0; c < L + 2; c++) begin
            idle();
            checks++;
            if (bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL midreset_leak cyc=%0d got valid=%b want 0", c, bus.out_valid);
            end
        end
        for (int c = 0; c < 4 + L + 2; c++) begin
            tick(1'b0, 1'b1, c < 4, 1'b0, 64'd13, rnd_lanes(), rnd_lanes());
            if (bus.out_valid === 1'b1) begin
                nout++;
                checks++;
                if (bus.out_last !== (nout == 4)) begin
                    errors++;
                    $display("FAIL midreset_last beat=%0d got %b want %b", nout, bus.out_last, (nout == 4));
                end
            end
        end
        checks++;
        if (nout != 4) begin
            errors++;
            $display("FAIL midreset_count got %0d want 4", nout);
        end
    endtask

    task automatic test_edge();
        lanes_t a1, b1, a2, b2;
        a1 = rnd_lanes(); b1 = rnd_lanes();
        a2 = rnd_lanes(); b2 = '0;
        for (int k = 1; k < R; k++) begin
            a2[k] = 64'hFFFF_FFFF_FFFF_FFFE;
            b2[k] = 64'hFFFF_FFFF_FFFF_FFFE;
        end
        tick(1'b0, 1'b1, 1'b1, 1'b0, 64'd0, a1, b1);
        tick(1'b0, 1'b1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, a2, b2);
        for (int c = 3; c <= 7; c++) begin
            idle();
            if (c == 4) begin
                checks++;
                if (bus.out_valid !== 1'b1 || bus.out_data[0] !== a1[0] || bus.out_data[1] !== 64'd0 ||
                    bus.out_data[2] !== 64'd0 || bus.out_data[3] !== 64'd0) begin
                    errors++;
                    $display("FAIL edge_n0 v=%b got %h want lanes1.. 0, l0 %h", bus.out_valid,
                             bus.out_data, a1[0]);
                end
            end
            if (c == 5) begin
                checks++;
                if (bus.out_valid !== 1'b1 || bus.out_data[1] !== 64'd1 ||
                    bus.out_data[2] !== 64'd1 || bus.out_data[3] !== 64'd1) begin
                    errors++;
                    $display("FAIL edge_nmax v=%b got %h want lanes1.. 1", bus.out_valid, bus.out_data);
                end
            end
        end
    endtask

    task automatic test_random();
        logic         en, v, byp;
        logic [D-1:0] n;
        for (int c = 0; c < 14000; c++) begin
            en  = $urandom_range(0, 9) != 0;
            v   = $urandom_range(0, 9) < 7;
            byp = $urandom_range(0, 9) == 0;
            case ($urandom_range(0, 3))
                0:       n = 64'($urandom_range(0, 3));
                1:       n = 64'($urandom_range(2, 1000));
                default: n = rnd64();
            endcase
            tick(1'b0, en, v, byp, n, rnd_lanes(), rnd_lanes());
            checks++;
            if (bus.out_valid !== exp_valid || bus.out_last !== exp_last) begin
                errors++;
                $display("FAIL rand_ctl cyc=%0d got v=%b l=%b want v=%b l=%b", c, bus.out_valid,
                         bus.out_last, exp_valid, exp_last);
            end
            if (exp_valid) begin
                checks++;
                if (bus.out_data !== exp_data) begin
                    errors++;
                    $display("FAIL rand_data cyc=%0d got %h want %h", c, bus.out_data, exp_data);
                end
            end
        end
    endtask

    initial begin
        bus.en       = 1'b0;
        bus.in_valid = 1'b0;
        bus.bypass   = 1'b0;
        bus.mod_n    = '0;
        bus.in_data  = '0;
        bus.tf_in    = '0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_back_to_back();
        test_bypass_mod();
        test_frame();
        test_reset_midflight();
        test_edge();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
